load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the execute stage and `Data_Memory`. It accepts load/store requests over a valid/ready handshake and absorbs store bursts in a small in-order write buffer. The buffer drains into `Data_Memory` on idle port cycles. Loads are sequenced onto the same single memory port.

## Interface
Parameters:
- `DATA_W`, 16: data width; matches `Data_Memory`.
- `ADDR_W`, 16: request address width.
- `DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `MATCH_W`, 3: address bits compared for forwarding; equals the memory's decoded address bits, so aliases match.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W`: request address.
- `req_wdata` in `DATA_W`: store data.
- `rsp_valid` out 1: one-cycle load-data pulse.
- `rsp_rdata` out `DATA_W`: load data; holds until the next response.
- `busy` out 1: buffer non-empty or load in flight.
- `mem_access_addr` out 16: to `Data_Memory`.
- `mem_write_data` out 16: to `Data_Memory`.
- `mem_write_en` out 1: to `Data_Memory`.
- `mem_read` out 1: to `Data_Memory`.
- `mem_read_data` in 16: from `Data_Memory`; combinational read.

## Operation
- FSM states: IDLE and LOAD.
  - IDLE → LOAD on load acceptance.
  - LOAD → IDLE unconditionally after one cycle.
- Write buffer: circular FIFO with head/tail pointers and a count of 0..`DEPTH`.
- Store acceptance:
  - `req_ready` = IDLE && count < `DEPTH`.
  - On acceptance, {addr, wdata} is written at the tail.
- Load acceptance:
  - `req_ready` = IDLE, plus the forwarding rule in Configuration.
  - The address is captured and the FSM enters LOAD.
- Drain (IDLE only): fires when count ≠ 0 and no request is accepted this cycle.
  - Head entry drives `mem_access_addr`/`mem_write_data` with `mem_write_en`=1.
  - The entry pops at the clock edge.
  - Drain order is strictly FIFO.
- LOAD cycle:
  - No drain and no acceptance.
  - On a miss, `mem_read`=1, `mem_access_addr`=load address, and `mem_read_data` is registered into `rsp_rdata`.
- Port arbitration: only one of `mem_write_en`/`mem_read` is high per cycle.
  - When neither is high, the memory outputs are 0.
- `busy` = (count ≠ 0) || LOAD.

## Timing
- Reset values:
  - `req_ready`=0 while `rst` is high, then 1 after release.
  - All other outputs are 0, count=0, pointers=0, FSM in IDLE.
- Reset mid-operation: all buffered stores are discarded and an in-flight load is dropped. No `rsp_valid` follows.
- Store to memory: an accepted store reaches memory no earlier than the first later cycle with no accepted request.
- Load latency: accepted at edge N; LOAD cycle is N→N+1; `rsp_valid` is high for the single cycle after edge N+1.
- Full buffer: `req_ready`=0 for stores. That cycle drains one entry, and the store is accepted on the next cycle.
  - There is no same-cycle enqueue-on-pop bypass.
- Back-to-back accepted requests starve the drain. This is intentional.
- Pointers wrap modulo `DEPTH`. Count never exceeds `DEPTH` and never underflows.

## Configuration
- `LSU_STORE_FWD_EN` defined:
  - Loads are accepted regardless of buffer occupancy.
  - In LOAD, the youngest buffer entry whose `addr[MATCH_W-1:0]` matches supplies the data, with `mem_read`=0.
  - With no match, data comes from memory.
- `LSU_STORE_FWD_EN` undefined:
  - Loads require count==0, so `req_ready`=0 for loads while the buffer is non-empty.
  - Drain proceeds, because the stalled load is not accepted.
  - No comparators are built.

## Test plan
- Assert `rst` with 3 entries buffered; release → count 0, no `mem_write_en` ever issued for those entries, `req_ready`=1, all memory outputs 0.
- Single store addr 0x0003, data 0xA5A5, then idle → next cycle `mem_write_en`=1 with `mem_access_addr`=0x0003 and `mem_write_data`=0xA5A5; `busy`=0 the cycle after.
- Five consecutive stores to addresses 0..4 with `req_valid` held, `DEPTH`=4 → four accepted; `req_ready`=0 on the fifth cycle while addr 0 drains; fifth accepted the next cycle; memory writes occur in order 0,1,2,3,4.
- Memory[2]=0xBEEF, buffer empty, load 2 → `mem_read`=1 for one cycle; `rsp_valid` pulses 2 cycles after acceptance with `rsp_rdata`=0xBEEF.
- Store 0x1111 to 0x0005, store 0x2222 to 0x000D, then load 0x0005:
  - With `LSU_STORE_FWD_EN`: accepted immediately; `rsp_rdata`=0x2222 and `mem_read` stays 0.
  - Without it: load stalls until both drains complete, then reads 0x2222 from memory.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit sharing one Data_Memory port.
// Stores are absorbed by an in-order write buffer that drains on idle port cycles.
// Loads run through a one-cycle LOAD state and return a single rsp_valid pulse.
// Optional feature macro: LSU_STORE_FWD_EN (store-to-load forwarding from the buffer).
module load_store_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MATCH_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [15:0]       mem_access_addr,
  output logic [15:0]       mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [15:0]       mem_read_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Reject parameter sets the buffer indexing and forwarding compare cannot support.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (MATCH_W > ADDR_W) || (MATCH_W == 0))
  begin : g_bad_param
    $error("load_store_unit: invalid DEPTH or MATCH_W");
  end

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   buf_addr_q [DEPTH];
  logic [DATA_W-1:0]   buf_data_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   ld_addr_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic store_ok;
  logic load_ok;
  logic accept;
  logic push;
  logic ld_go;
  logic drain;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

`ifdef LSU_STORE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Youngest valid entry aliasing the load address wins; scan oldest to youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (buf_addr_q[fwd_idx][MATCH_W-1:0] == ld_addr_q[MATCH_W-1:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Request acceptance: stores need a free slot, loads need IDLE (and an empty buffer without forwarding).
  always_comb begin
    store_ok = (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
`ifdef LSU_STORE_FWD_EN
    load_ok  = (state_q == IDLE);
`else
    load_ok  = (state_q == IDLE) && (count_q == '0);
`endif
    req_ready = !rst && (req_we ? store_ok : load_ok);
  end

  assign accept = req_valid && req_ready;
  assign push   = accept && req_we;
  assign ld_go  = accept && !req_we;
  assign drain  = (state_q == IDLE) && (count_q != '0) && !accept;

  // Buffer pointer and occupancy bookkeeping; push and drain are mutually exclusive.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d  = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(1);
    end else if (drain) begin
      head_d  = head_q + PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  // Single memory port: drain write or load read, otherwise all zeros.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (drain) begin
      mem_access_addr = 16'(buf_addr_q[head_q]);
      mem_write_data  = 16'(buf_data_q[head_q]);
      mem_write_en    = 1'b1;
    end else if ((state_q == LOAD) && !fwd_hit) begin
      mem_access_addr = 16'(ld_addr_q);
      mem_read        = 1'b1;
    end
  end

  assign busy      = (count_q != '0) || (state_q == LOAD);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // State register, write buffer storage and load FSM with registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ld_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rsp_valid_q <= 1'b0;
      if (push) begin
        buf_addr_q[tail_q] <= req_addr;
        buf_data_q[tail_q] <= req_wdata;
      end
      case (state_q)
        IDLE: begin
          if (ld_go) begin
            ld_addr_q <= req_addr;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= fwd_hit ? fwd_data : DATA_W'(mem_read_data);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// program-order memory model and an in-order expected-write queue.
module tb_load_store_unit;

`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  bit   [15:0] mem       [8];
  bit   [15:0] model_mem [8];
  logic [31:0] exp_wr [$];
  logic [15:0] exp_ld [$];
  int          ld_cyc [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          writes_seen = 0;

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .busy            (busy),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data_Memory stand-in: 8 decoded words, combinational read, clocked write.
  assign mem_read_data = mem[mem_access_addr[2:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: port exclusivity, write order, load data and latency, model update.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en || mem_read)
        check("port_excl", 64'(mem_write_en & mem_read), 64'(0));
      else
        check("idle_port_zero", 64'({mem_access_addr, mem_write_data}), 64'(0));
      if (mem_write_en) begin
        writes_seen++;
        check("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
        if (exp_wr.size() != 0)
          check("wr_order", 64'({mem_access_addr, mem_write_data}), 64'(exp_wr.pop_front()));
      end
      if (rsp_valid) begin
        check("rsp_expected", 64'(exp_ld.size() != 0), 64'(1));
        if (exp_ld.size() != 0) begin
          check("rsp_data", 64'(rsp_rdata), 64'(exp_ld.pop_front()));
          check("rsp_latency", 64'(cyc - ld_cyc.pop_front()), 64'(2));
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          exp_wr.push_back({req_addr, req_wdata});
          model_mem[req_addr[2:0]] = req_wdata;
        end else begin
          exp_ld.push_back(model_mem[req_addr[2:0]]);
          ld_cyc.push_back(cyc);
        end
      end
    end
  end

  // Present one request from #1 after an edge; return #1 after its acceptance edge.
  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int waited);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready) check("req_timeout", 64'(waited), 64'(0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_wr.delete();
    exp_ld.delete();
    ld_cyc.delete();
    model_mem = mem;
    @(negedge clk);
    check("rst_ready_low", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'(1));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_mem", 64'({mem_write_en, mem_read, mem_access_addr, mem_write_data}), 64'(0));
    check("post_rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          wv [5];
    int          ws;
    logic [15:0] a;
    logic [15:0] d;

    // Power-on reset.
    apply_reset();

    // Single store then idle: drains on the very next cycle.
    do_req(1'b1, 16'h0003, 16'hA5A5, w);
    @(negedge clk);
    check("single_wen", 64'(mem_write_en), 64'(1));
    check("single_addr", 64'(mem_access_addr), 64'h0003);
    check("single_data", 64'(mem_write_data), 64'hA5A5);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("single_busy_after", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    // Five back-to-back stores into a 4-entry buffer.
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 16'(i), 16'h0100 + 16'(i), wv[i]);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_wait%0d", i), 64'(wv[i]), (i == 4) ? 64'(1) : 64'(0));
    end
    wait_idle();

    // Load from memory after the buffer is empty.
    do_req(1'b1, 16'h0002, 16'hBEEF, w);
    wait_idle();
    do_req(1'b0, 16'h0002, 16'h0000, w);
    @(negedge clk);
    check("load_mem_read", 64'(mem_read), 64'(1));
    check("load_addr", 64'(mem_access_addr), 64'h0002);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("load_rsp_valid", 64'(rsp_valid), 64'(1));
    check("load_rsp_data", 64'(rsp_rdata), 64'hBEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("load_rsp_pulse", 64'(rsp_valid), 64'(0));
    check("load_rsp_hold", 64'(rsp_rdata), 64'hBEEF);
    @(posedge clk);
    #1;

    // Aliased stores then load: forwarding picks the youngest, otherwise the load waits.
    do_req(1'b1, 16'h0005, 16'h1111, w);
    do_req(1'b1, 16'h000D, 16'h2222, w);
    do_req(1'b0, 16'h0005, 16'h0000, w);
    check("fwd_wait", 64'(w), FWD ? 64'(0) : 64'(2));
    @(negedge clk);
    check("fwd_mem_read", 64'(mem_read), FWD ? 64'(0) : 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fwd_rsp_valid", 64'(rsp_valid), 64'(1));
    check("fwd_rsp_data", 64'(rsp_rdata), 64'h2222);
    @(posedge clk);
    #1;
    wait_idle();

    // Reset with three stores buffered: none may reach memory.
    ws = writes_seen;
    do_req(1'b1, 16'h0006, 16'h6666, w);
    do_req(1'b1, 16'h0007, 16'h7777, w);
    do_req(1'b1, 16'h0000, 16'h0A0A, w);
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    check("rst_drop_writes", 64'(writes_seen), 64'(ws));
    check("rst_drop_mem6", 64'(mem[6]), 64'(model_mem[6]));

    // Reset during the LOAD cycle: the response is dropped.
    do_req(1'b0, 16'h0002, 16'h0000, w);
    apply_reset();
    @(negedge clk);
    check("rst_load_no_rsp", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;

    // Random mixed traffic against the program-order model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else begin
        a = 16'($urandom_range(0, 15));
        d = 16'($urandom);
        do_req(1'($urandom_range(0, 1)), a, d, w);
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("final_wr_queue", 64'(exp_wr.size()), 64'(0));
    check("final_ld_queue", 64'(exp_ld.size()), 64'(0));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("final_mem%0d", i), 64'(mem[i]), 64'(model_mem[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
